line_buffer_ctrl: RTL and testbench

- Ping-pong scanline controller for the VGA renderer.
- Owns two `line_buffer` instances (640 x 24-bit, single address port, registered read). One bank is the front bank, read by the display for the current line; the other is the back bank, filled by the sprite/tile drawer for the next line.
- Swaps banks on every `line_start`, requests the next line from the drawer, and clears the front bank to the background colour as it is scanned out.
- Sits between the VGA timing generator and the draw engine.

---
 rtl/lb_pkg.sv | 19 +
 rtl/lb_bank_mux.sv | 64 ++++++
 rtl/line_buffer.sv | 29 ++
 rtl/line_buffer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_pkg.sv
// Shared types and constants for the ping-pong scanline controller.
package lb_pkg;

    localparam int LB_WIDTH = 640;
    localparam int LB_AW    = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t LB_TRANSPARENT = 24'hFF00FF;
    localparam rgb_t LB_BLACK       = 24'h000000;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_WAIT = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lb_bank_mux.sv
// Steers the display (front) and drawer (back) ports onto the two physical banks.
module lb_bank_mux
    import lb_pkg::*;
#(
    parameter int AW = LB_AW
) (
    input  logic          front_sel_i,
    input  logic          init_i,
    input  logic [AW-1:0] clr_addr_i,
    input  rgb_t          bg_color_i,
    input  logic          disp_en_i,
    input  logic [AW-1:0] disp_x_i,
    input  logic          back_we_i,
    input  logic [AW-1:0] draw_x_i,
    input  rgb_t          draw_color_i,
    output logic [AW-1:0] addr0_o,
    output logic          we0_o,
    output rgb_t          din0_o,
    output logic [AW-1:0] addr1_o,
    output logic          we1_o,
    output rgb_t          din1_o
);

    logic [AW-1:0] front_addr_d;
    logic          front_we_d;
    rgb_t          front_din_d;
    logic [AW-1:0] back_addr_d;
    logic          back_we_d;
    rgb_t          back_din_d;

    always_comb begin
        front_addr_d = disp_x_i;
        front_we_d   = disp_en_i;
        front_din_d  = bg_color_i;
        back_addr_d  = draw_x_i;
        back_we_d    = back_we_i;
        back_din_d   = draw_color_i;

        addr0_o = front_addr_d;
        we0_o   = front_we_d;
        din0_o  = front_din_d;
        addr1_o = back_addr_d;
        we1_o   = back_we_d;
        din1_o  = back_din_d;

        // Power-up clear drives both banks in lockstep, ignoring the display.
        if (init_i) begin
            addr0_o = clr_addr_i;
            we0_o   = 1'b1;
            din0_o  = bg_color_i;
            addr1_o = clr_addr_i;
            we1_o   = 1'b1;
            din1_o  = bg_color_i;
        end else if (front_sel_i) begin
            addr0_o = back_addr_d;
            we0_o   = back_we_d;
            din0_o  = back_din_d;
            addr1_o = front_addr_d;
            we1_o   = front_we_d;
            din1_o  = front_din_d;
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Single-port scanline RAM with registered read; the read returns the pre-write contents.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 24
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] dout_q;
    logic          in_range_d;

    assign in_range_d = ({1'b0, addr_i} < (AW+1)'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (we_i && in_range_d) begin
            mem_q[addr_i] <= din_i;
        end
        dout_q <= in_range_d ? mem_q[addr_i] : '0;
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong scanline controller: display scans and clears the front bank while
// the draw engine paints the next line into the back bank.
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int   WIDTH       = LB_WIDTH,
    parameter int   AW          = LB_AW,
    parameter rgb_t TRANSPARENT = LB_TRANSPARENT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          line_start,
    input  logic          disp_en,
    input  logic [AW-1:0] disp_x,
    input  rgb_t          bg_color,
    output rgb_t          pixel_out,
    output logic          line_req,
    input  logic          draw_valid,
    output logic          draw_ready,
    input  logic [AW-1:0] draw_x,
    input  rgb_t          draw_color,
    input  logic          draw_last,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic          init_done
);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          front_sel_q;
    logic          line_req_q;
    logic          draw_ready_q;
    logic          overrun_q;
    logic          init_done_q;
    logic          disp_vld_q;
    logic          bank_sel_q;

    logic          accept_d;
    logic          drop_d;
    logic          back_we_d;
    logic          last_d;
    logic          ovr_set_d;
    logic          disp_vld_d;

    logic [AW-1:0] addr0, addr1;
    logic          we0, we1;
    rgb_t          din0, din1, dout0, dout1;

    assign accept_d   = draw_valid && draw_ready_q;
    assign drop_d     = (draw_color == TRANSPARENT) || ({1'b0, draw_x} >= (AW+1)'(WIDTH));
    assign back_we_d  = accept_d && !drop_d;
    assign last_d     = accept_d && draw_last;
    // A last beat landing on the swap cycle completes the old line, so it is not an overrun.
    assign ovr_set_d  = line_start && (state_q == ST_FILL) && !last_d;
    assign disp_vld_d = disp_en && (state_q != ST_INIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            front_sel_q  <= 1'b0;
            line_req_q   <= 1'b0;
            draw_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            line_req_q <= 1'b0;
            if (ovr_set_d) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_INIT: begin
                    if (cnt_q == AW'(WIDTH-1)) begin
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                        state_q     <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT, ST_DONE: begin
                    if (line_start) begin
                        front_sel_q  <= ~front_sel_q;
                        line_req_q   <= 1'b1;
                        draw_ready_q <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (line_start) begin
                        front_sel_q <= ~front_sel_q;
                        line_req_q  <= 1'b1;
                    end else if (last_d) begin
                        draw_ready_q <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end
                default: begin
                    state_q      <= ST_INIT;
                    draw_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Display pipe: read issued this cycle, pixel presented next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_vld_q <= 1'b0;
            bank_sel_q <= 1'b0;
        end else begin
            disp_vld_q <= disp_vld_d;
            bank_sel_q <= front_sel_q;
        end
    end

    lb_bank_mux #(
        .AW (AW)
    ) u_mux (
        .front_sel_i  (front_sel_q),
        .init_i       (state_q == ST_INIT),
        .clr_addr_i   (cnt_q),
        .bg_color_i   (bg_color),
        .disp_en_i    (disp_en),
        .disp_x_i     (disp_x),
        .back_we_i    (back_we_d),
        .draw_x_i     (draw_x),
        .draw_color_i (draw_color),
        .addr0_o      (addr0),
        .we0_o        (we0),
        .din0_o       (din0),
        .addr1_o      (addr1),
        .we1_o        (we1),
        .din1_o       (din1)
    );

    line_buffer #(
        .DEPTH (WIDTH),
        .AW    (AW),
        .DW    (24)
    ) u_bank0 (
        .clk_i  (clk),
        .addr_i (addr0),
        .we_i   (we0),
        .din_i  (din0),
        .dout_o (dout0)
    );

    line_buffer #(
        .DEPTH (WIDTH),
        .AW    (AW),
        .DW    (24)
    ) u_bank1 (
        .clk_i  (clk),
        .addr_i (addr1),
        .we_i   (we1),
        .din_i  (din1),
        .dout_o (dout1)
    );

    assign pixel_out  = disp_vld_q ? (bank_sel_q ? dout1 : dout0) : LB_BLACK;
    assign line_req   = line_req_q;
    assign draw_ready = draw_ready_q;
    assign overrun    = overrun_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a two-bank memory model of the scanline contents.
module tb_line_buffer_ctrl;

    localparam int W  = 640;
    localparam int AW = 10;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          line_start;
    logic          disp_en;
    logic [AW-1:0] disp_x;
    logic [23:0]   bg_color;
    logic [23:0]   pixel_out;
    logic          line_req;
    logic          draw_valid;
    logic          draw_ready;
    logic [AW-1:0] draw_x;
    logic [23:0]   draw_color;
    logic          draw_last;
    logic          overrun;
    logic          overrun_clr;
    logic          init_done;

    line_buffer_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .disp_en     (disp_en),
        .disp_x      (disp_x),
        .bg_color    (bg_color),
        .pixel_out   (pixel_out),
        .line_req    (line_req),
        .draw_valid  (draw_valid),
        .draw_ready  (draw_ready),
        .draw_x      (draw_x),
        .draw_color  (draw_color),
        .draw_last   (draw_last),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: contents of each bank and which bank the display currently owns.
    logic [23:0] mem [2][W];
    int          mfront;
    logic [23:0] got [W];

    // Expected pixel for the read issued at the next rising edge.
    logic        exp_en  = 1'b0;
    logic [23:0] exp_pix = '0;
    int          exp_x   = 0;

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        logic        c_en;
        logic [23:0] c_pix;
        int          c_x;
        c_en  = exp_en;
        c_pix = exp_pix;
        c_x   = exp_x;
        #2;
        if (c_en) begin
            check($sformatf("pixel_x%0d", c_x), pixel_out, c_pix);
            got[c_x] = pixel_out;
        end else begin
            check("pixel_idle", pixel_out, 24'h0);
        end
    end

    task automatic model_fill(input logic [23:0] c);
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < W; x++)
                mem[b][x] = c;
    endtask

    task automatic scan();
        for (int x = 0; x < W; x++) begin
            @(negedge clk);
            disp_en = 1'b1;
            disp_x  = x[AW-1:0];
            exp_en  = 1'b1;
            exp_x   = x;
            exp_pix = mem[mfront][x];
            mem[mfront][x] = bg_color;
        end
        @(negedge clk);
        disp_en = 1'b0;
        exp_en  = 1'b0;
    endtask

    task automatic do_line_start();
        @(negedge clk);
        line_start = 1'b1;
        mfront     = 1 - mfront;
        @(negedge clk);
        line_start = 1'b0;
        check("line_req_pulse", {23'd0, line_req}, 24'd1);
        check("ready_after_swap", {23'd0, draw_ready}, 24'd1);
        @(negedge clk);
        check("line_req_low", {23'd0, line_req}, 24'd0);
    endtask

    task automatic beat(input int x, input logic [23:0] c, input logic last);
        @(negedge clk);
        check("beat_ready", {23'd0, draw_ready}, 24'd1);
        draw_valid = 1'b1;
        draw_x     = x[AW-1:0];
        draw_color = c;
        draw_last  = last;
        if (x < W && c != KEY) mem[1-mfront][x] = c;
        @(negedge clk);
        draw_valid = 1'b0;
        draw_last  = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared", {23'd0, overrun}, 24'd0);
    endtask

    initial begin
        reset_n = 1'b0; line_start = 1'b0; disp_en = 1'b0; disp_x = '0;
        bg_color = 24'h5C94FC; draw_valid = 1'b0; draw_x = '0; draw_color = '0;
        draw_last = 1'b0; overrun_clr = 1'b0; mfront = 0;

        repeat (3) @(negedge clk);
        check("rst_pixel", pixel_out, 24'h0);
        check("rst_line_req", {23'd0, line_req}, 24'd0);
        check("rst_ready", {23'd0, draw_ready}, 24'd0);
        check("rst_overrun", {23'd0, overrun}, 24'd0);
        check("rst_init_done", {23'd0, init_done}, 24'd0);
        reset_n = 1'b1;

        repeat (639) @(negedge clk);
        check("init_done_639", {23'd0, init_done}, 24'd0);
        @(negedge clk);
        check("init_done_640", {23'd0, init_done}, 24'd1);
        check("wait_ready", {23'd0, draw_ready}, 24'd0);
        model_fill(bg_color);

        scan();
        do_line_start();
        scan();

        beat(10, 24'hFF0000, 1'b0);
        beat(11, 24'hFF00FF, 1'b1);
        check("ready_after_last", {23'd0, draw_ready}, 24'd0);
        do_line_start();
        check("no_overrun_from_done", {23'd0, overrun}, 24'd0);
        scan();
        check("lit_x10", got[10], 24'hFF0000);
        check("lit_x11_key", got[11], 24'h5C94FC);
        check("lit_x12", got[12], 24'h5C94FC);

        do_line_start();
        do_line_start();
        check("overrun_set", {23'd0, overrun}, 24'd1);
        scan();
        check("lit_rescan_x10", got[10], 24'h5C94FC);
        check("overrun_sticky", {23'd0, overrun}, 24'd1);
        clr_pulse();

        @(negedge clk);
        line_start  = 1'b1;
        overrun_clr = 1'b1;
        mfront      = 1 - mfront;
        @(negedge clk);
        line_start  = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_set_wins", {23'd0, overrun}, 24'd1);
        check("line_req_sim", {23'd0, line_req}, 24'd1);
        clr_pulse();

        beat(700, 24'h123456, 1'b0);
        beat(5, 24'h00FF00, 1'b0);
        beat(5, 24'h0000FF, 1'b1);
        do_line_start();
        scan();
        check("lit_x5_painter", got[5], 24'h0000FF);
        check("overrun_clean", {23'd0, overrun}, 24'd0);

        // Beat accepted on the swap cycle belongs to the outgoing back bank.
        @(negedge clk);
        check("swap_beat_ready", {23'd0, draw_ready}, 24'd1);
        line_start = 1'b1; draw_valid = 1'b1; draw_x = 10'd20;
        draw_color = 24'hABCDEF; draw_last = 1'b0;
        mem[1-mfront][20] = 24'hABCDEF;
        mfront = 1 - mfront;
        @(negedge clk);
        line_start = 1'b0; draw_valid = 1'b0;
        check("swap_beat_overrun", {23'd0, overrun}, 24'd1);
        scan();
        check("lit_x20_swapbeat", got[20], 24'hABCDEF);

        @(negedge clk);
        draw_valid = 1'b1; draw_x = 10'd30; draw_color = 24'h111111;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #2;
        check("arst_ready", {23'd0, draw_ready}, 24'd0);
        check("arst_overrun", {23'd0, overrun}, 24'd0);
        check("arst_init_done", {23'd0, init_done}, 24'd0);
        check("arst_line_req", {23'd0, line_req}, 24'd0);
        check("arst_pixel", pixel_out, 24'h0);
        @(negedge clk);
        draw_valid = 1'b0;
        bg_color   = 24'h202020;
        mfront     = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (640) @(negedge clk);
        check("reinit_done", {23'd0, init_done}, 24'd1);
        model_fill(bg_color);
        scan();
        check("lit_reinit_x30", got[30], 24'h202020);
        do_line_start();
        scan();
        check("lit_reinit_x20", got[20], 24'h202020);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
